// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell (two half adders + OR)
// adds two WIDTH-bit operands LSB first, one bit per clock, behind valid/ready.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high. in_ready is high only in IDLE and out_valid only in DONE, both decoded
    // from state alone; sum/cout hold steady while out_valid is high and out_ready low.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             p, g1, s, g2, carry_nxt, last_bit;

    // Shared full-adder cell.
    always_comb begin
        p         = a_sh[0] ^ b_sh[0];
        g1        = a_sh[0] & b_sh[0];
        s         = p ^ carry;
        g2        = p & carry;
        carry_nxt = g1 | g2;
        last_bit  = (cnt == LAST);
        sum_nxt   = (sum_sh >> 1) | (WIDTH'(s) << (WIDTH - 1));
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign state_dbg = state;

    // sum/cout are separate from the shift register so the visible result only
    // changes when an operation completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_nxt;
                    carry  <= carry_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        sum  <= sum_nxt;
                        cout <= carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
